calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Sequential accumulator controller that drives the team's 4-bit signed combinational calculator (add / subtract / absolute value with overflow flag).
- Accepts one operation request at a time and presents the accumulator and operand to the calculator on registered outputs.
- Captures the result and overflow, then commits to the accumulator or enters a sticky error state.
- Sits between the board key/switch front end and the calculator; its outputs feed the HEX display decoders.

Parameters:
- WIDTH, 4, operand/accumulator/result width (two's complement).
- COUNT_W, 8, width of the completed-operation counter.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- start  in  1  operation request, sampled only in IDLE/ERROR.
- op  in  3  opcode: 000 ADD, 001 SUB, 010 ABS, 011 LOAD, 100 CLEAR, 101-111 illegal.
- operand  in  WIDTH  signed B operand.
- busy  out  1  high while an accepted operation is in flight.
- done  out  1  one-cycle pulse, coincident with the first cycle that the committed acc/err value is visible.
- acc  out  WIDTH  signed accumulator.
- err  out  1  sticky overflow flag.
- op_count  out  COUNT_W  number of successfully committed operations.
- alu_a  out  WIDTH  registered calculator A input (= acc).
- alu_b  out  WIDTH  registered calculator B input (= latched operand).
- alu_op  out  3  registered calculator opcode.
- alu_r  in  WIDTH  calculator result.
- alu_ovf  in  1  calculator overflow.

Behaviour:
- Reset (RESET_N=0 at a rising edge):
  - state=IDLE; acc, alu_a, alu_b, alu_op, op_count = 0; busy, done, err = 0.
  - Reset overrides everything, including mid-operation; an in-flight operation is abandoned with no done.
- States: IDLE, ISSUE, CAPTURE, ERROR (2-bit encoding).
- IDLE:
  - start=1 with a legal op: latch op into op_q and operand into b_q; load alu_a=acc, alu_b=operand, alu_op (op for 000-010, 000 for LOAD/CLEAR); go to ISSUE.
  - start=1 with an illegal op (101-111): ignored; stay IDLE; no done.
- ISSUE: one settling cycle for the combinational calculator; always go to CAPTURE.
- CAPTURE: sample alu_r and alu_ovf, then commit:
  - ADD/SUB/ABS with alu_ovf=0: acc<=alu_r; op_count++; go to IDLE.
  - ADD/SUB/ABS with alu_ovf=1: acc unchanged; err<=1; op_count unchanged; go to ERROR.
  - LOAD: acc<=b_q; CLEAR: acc<=0. Calculator output ignored; op_count++; go to IDLE.
  - done<=1 on every CAPTURE exit, including the overflow case.
- ERROR:
  - busy=0, err=1.
  - Only start with op=CLEAR is accepted; it follows ISSUE -> CAPTURE. At commit: acc<=0, err<=0, op_count++, done, next state IDLE.
  - All other starts are ignored, with no done.
- Arithmetic is performed by the calculator, not here:
  - SUB is acc - operand.
  - ABS ignores operand; ABS of -8 reports overflow.
- Timing:
  - start high in cycle 0 gives busy high in cycles 1-2, and done high with the updated acc/err/op_count in cycle 3.
  - A new start is accepted in cycle 3, giving a throughput of one operation per 3 cycles.
- start while busy (ISSUE/CAPTURE) is ignored and not queued. Level-held start re-triggers each time the block returns to IDLE.
- op/operand changes after acceptance have no effect; b_q and alu_* stay stable through CAPTURE.
- op_count wraps from 2^COUNT_W-1 to 0.
- done is low in every cycle other than the single pulse.

Test Plan:
1. Reset, then LOAD 3 (start in cycle 0) -> busy in cycles 1-2; in cycle 3: done=1, acc=3, err=0, op_count=1.
2. From acc=3: ADD 4 -> acc=7, no err. Then ADD 1 -> alu_ovf=1, done pulses, acc stays 7, err=1, state ERROR, op_count=2. A further ADD 1 is ignored: no busy, no done.
3. In ERROR: CLEAR -> cycle 3: acc=0, err=0, done=1, op_count=3. Then ADD 1 -> acc=1.
4. LOAD -6 (1010), then SUB 2 -> acc=-8 (1000), no err. Then SUB 1 -> overflow, err=1, acc stays -8.
5. LOAD -5, ABS -> acc=5. Then CLEAR, LOAD -8, ABS -> err=1, acc stays -8.
6. The following must each leave acc/err/op_count unchanged with no done, and state=IDLE with all outputs 0 after the reset:
   - op=110 with start -> no busy.
   - start held high across a busy window -> only the first request executes within that window.
   - RESET_N=0 during ISSUE.

Source files
------------

// File: rtl/calc_sequencer.sv
// Accumulator sequencer for the 4-bit signed calculator: issues one operation at a time,
// captures the result and commits it to the accumulator or latches a sticky overflow error.
module calc_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   operand,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   acc,
  output logic               err,
  output logic [COUNT_W-1:0] op_count,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_r,
  input  logic               alu_ovf
);

  localparam logic [2:0] OpAdd   = 3'b000;
  localparam logic [2:0] OpSub   = 3'b001;
  localparam logic [2:0] OpAbs   = 3'b010;
  localparam logic [2:0] OpLoad  = 3'b011;
  localparam logic [2:0] OpClear = 3'b100;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2,
    StError   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [2:0]         alu_op_q, alu_op_d;

  logic               op_legal;
  logic               op_is_arith;
  logic               accept;

  assign op_legal    = (op <= OpClear);
  assign op_is_arith = (op == OpAdd) || (op == OpSub) || (op == OpAbs);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    b_d        = b_q;
    acc_d      = acc_q;
    err_d      = err_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    op_count_d = op_count_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    accept     = 1'b0;

    unique case (state_q)
      StIdle: begin
        accept = start && op_legal;
      end
      StIssue: begin
        busy_d  = 1'b1;
        state_d = StCapture;
      end
      StCapture: begin
        done_d  = 1'b1;
        state_d = StIdle;
        unique case (op_q)
          OpAdd, OpSub, OpAbs: begin
            if (alu_ovf) begin
              err_d   = 1'b1;
              state_d = StError;
            end else begin
              acc_d      = alu_r;
              op_count_d = op_count_q + COUNT_W'(1);
            end
          end
          OpLoad: begin
            acc_d      = b_q;
            op_count_d = op_count_q + COUNT_W'(1);
          end
          OpClear: begin
            // Also the only way out of the sticky error state.
            acc_d      = '0;
            err_d      = 1'b0;
            op_count_d = op_count_q + COUNT_W'(1);
          end
          default: begin
            state_d = StIdle;
          end
        endcase
      end
      StError: begin
        accept = start && (op == OpClear);
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accept) begin
      op_d     = op;
      b_d      = operand;
      alu_a_d  = acc_q;
      alu_b_d  = operand;
      alu_op_d = op_is_arith ? op : OpAdd;
      busy_d   = 1'b1;
      state_d  = StIssue;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      op_q       <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      op_count_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      op_count_q <= op_count_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign acc      = acc_q;
  assign err      = err_q;
  assign op_count = op_count_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: arithmetic calculator stand-in plus a reference model of the
// accumulator/error/count behaviour, driven by directed steps followed by random operations.
module tb_calc_sequencer;
  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  operand;
  logic          busy, done, err, alu_ovf;
  logic [W-1:0]  acc, alu_a, alu_b, alu_r;
  logic [CW-1:0] op_count;
  logic [2:0]    alu_op;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_acc;
  bit m_err;
  int m_cnt;

  int calc_a, calc_b, calc_s;

  always #5 clk = ~clk;

  calc_sequencer #(.WIDTH(W), .COUNT_W(CW)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .start    (start),
    .op       (op),
    .operand  (operand),
    .busy     (busy),
    .done     (done),
    .acc      (acc),
    .err      (err),
    .op_count (op_count),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_r    (alu_r),
    .alu_ovf  (alu_ovf)
  );

  // Calculator stand-in: plain signed arithmetic with range check.
  always_comb begin
    calc_a = $signed(alu_a);
    calc_b = $signed(alu_b);
    case (alu_op)
      3'd0:    calc_s = calc_a + calc_b;
      3'd1:    calc_s = calc_a - calc_b;
      3'd2:    calc_s = (calc_a < 0) ? -calc_a : calc_a;
      default: calc_s = 0;
    endcase
    alu_r   = calc_s[W-1:0];
    alu_ovf = (calc_s > 7) || (calc_s < -8);
  end

  function automatic int sx(input logic [W-1:0] v);
    return $signed(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_acc"}, acc, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_cnt"}, op_count, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_op"}, alu_op, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check_idle_zero("reset");
    rst_n = 1'b1;
  endtask

  // One request: start in cycle 0, checks in cycles 1, 2 and 3. With hold, start stays
  // high through the busy window and op/operand are left untouched.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] b, input bit hold,
                       input string tag);
    bit          ok;
    int          s;
    int          n_acc;
    bit          n_err;
    int          n_cnt;
    int          old_acc;
    logic [2:0]  exp_aop;
    ok      = m_err ? (o == 3'd4) : (o <= 3'd4);
    n_acc   = m_acc;
    n_err   = m_err;
    n_cnt   = m_cnt;
    old_acc = m_acc;
    s       = 0;
    if (ok) begin
      case (o)
        3'd0:    s = m_acc + sx(b);
        3'd1:    s = m_acc - sx(b);
        3'd2:    s = (m_acc < 0) ? -m_acc : m_acc;
        3'd3:    s = sx(b);
        default: s = 0;
      endcase
      if (o <= 3'd2 && (s > 7 || s < -8)) begin
        n_err = 1'b1;
      end else begin
        n_acc = s;
        n_cnt = (m_cnt + 1) % (1 << CW);
        if (o == 3'd4) n_err = 1'b0;
      end
    end
    exp_aop = (o <= 3'd2) ? o : 3'd0;

    @(negedge clk);
    start   = 1'b1;
    op      = o;
    operand = b;
    @(posedge clk);
    #1;
    check({tag, "_c1_busy"}, busy, ok);
    check({tag, "_c1_done"}, done, 0);
    if (ok) begin
      check({tag, "_c1_alu_a"}, alu_a, old_acc[W-1:0]);
      check({tag, "_c1_alu_b"}, alu_b, b);
      check({tag, "_c1_alu_op"}, alu_op, exp_aop);
    end
    if (!hold) begin
      start   = 1'b0;
      op      = 3'($urandom);
      operand = W'($urandom);
    end
    @(posedge clk);
    #1;
    check({tag, "_c2_busy"}, busy, ok);
    check({tag, "_c2_done"}, done, 0);
    check({tag, "_c2_acc"}, acc, old_acc[W-1:0]);
    if (ok) begin
      check({tag, "_c2_alu_b"}, alu_b, b);
      check({tag, "_c2_alu_op"}, alu_op, exp_aop);
    end
    if (!hold) begin
      op      = 3'($urandom);
      operand = W'($urandom);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_c3_done"}, done, ok);
    check({tag, "_c3_busy"}, busy, 0);
    check({tag, "_c3_acc"}, acc, n_acc[W-1:0]);
    check({tag, "_c3_err"}, err, n_err);
    check({tag, "_c3_cnt"}, op_count, n_cnt[CW-1:0]);
    m_acc = n_acc;
    m_err = n_err;
    m_cnt = n_cnt;
  endtask

  initial begin
    logic [2:0]   r_op;
    logic [W-1:0] r_b;
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = '0;
    operand = '0;
    model_reset();
    do_reset();

    // Directed walk through the documented scenarios
    do_op(3'd3, 4'd3, 1'b0, "t1_load3");
    check("t1_acc_lit", acc, 4'd3);
    do_op(3'd0, 4'd4, 1'b0, "t2_add4");
    check("t2_acc_lit", acc, 4'd7);
    do_op(3'd0, 4'd1, 1'b0, "t2_add1_ovf");
    check("t2_err_lit", err, 1);
    check("t2_cnt_lit", op_count, 2);
    do_op(3'd0, 4'd1, 1'b0, "t2_add_in_err");
    do_op(3'd4, 4'd0, 1'b0, "t3_clear");
    check("t3_cnt_lit", op_count, 3);
    do_op(3'd0, 4'd1, 1'b0, "t3_add1");
    do_op(3'd3, 4'b1010, 1'b0, "t4_load_m6");
    do_op(3'd1, 4'd2, 1'b0, "t4_sub2");
    check("t4_acc_lit", acc, 4'b1000);
    do_op(3'd1, 4'd1, 1'b0, "t4_sub1_ovf");
    do_op(3'd4, 4'd0, 1'b0, "t5_clear0");
    do_op(3'd3, 4'b1011, 1'b0, "t5_load_m5");
    do_op(3'd2, 4'd9, 1'b0, "t5_abs");
    check("t5_acc_lit", acc, 4'd5);
    do_op(3'd4, 4'd0, 1'b0, "t5_clear");
    do_op(3'd3, 4'b1000, 1'b0, "t5_load_m8");
    do_op(3'd2, 4'd0, 1'b0, "t5_abs_ovf");
    check("t5_err_lit", err, 1);
    do_op(3'd4, 4'd0, 1'b0, "t6_clear");
    do_op(3'd6, 4'd2, 1'b0, "t6_illegal");
    do_op(3'd0, 4'd2, 1'b1, "t6_held");

    // Reset while the request is in ISSUE
    @(negedge clk);
    start   = 1'b1;
    op      = 3'd3;
    operand = 4'd5;
    @(posedge clk);
    #1;
    check("t6_rst_issue_busy", busy, 1);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_idle_zero("t6_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t6_rst_no_done", done, 0);
      check("t6_rst_acc", acc, 0);
    end

    // Random operations; errors are cleared more often to keep the counter moving
    for (int i = 0; i < 700; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_b  = W'($urandom);
      if (m_err && $urandom_range(0, 1) == 1) r_op = 3'd4;
      do_op(r_op, r_b, 1'($urandom_range(0, 3) == 0) && (r_op <= 3'd4), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
